// File: rtl/iobus_turn_arbiter_if.sv
// rtl/iobus_turn_arbiter_if.sv - requester/pad bus bundle for iobus_turn_arbiter
interface iobus_turn_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_dir;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      owner;
    logic               bus_oe;
    logic               bus_dir;
    logic               busy;
    logic [7:0]         preempt_cnt;

    modport master (
        output req, req_dir,
        input  gnt, owner, bus_oe, bus_dir, busy, preempt_cnt
    );

    modport slave (
        input  req, req_dir,
        output gnt, owner, bus_oe, bus_dir, busy, preempt_cnt
    );
endinterface

// File: rtl/iobus_turn_arbiter.sv
// rtl/iobus_turn_arbiter.sv - round-robin tri-state pad bus arbiter with break-before-make turnaround
// Optional forced-release counter enabled by IOBUS_TURN_ARB_STATS_EN.
module iobus_turn_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    iobus_turn_arbiter_if.slave  bus
);
    localparam int IW        = $clog2(NUM_REQ);
    localparam int HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int TW        = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam int TURN_LAST = TURN_CYC - 1;

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
    logic [IW-1:0]      owner_q, owner_nxt;
    logic [IW-1:0]      ptr_q, ptr_nxt;
    logic               oe_q, oe_nxt;
    logic               dir_q, dir_nxt;
    logic               busy_q, busy_nxt;
    logic [HW-1:0]      hold_q, hold_nxt;
    logic [TW-1:0]      turn_q, turn_nxt;
    logic [IW-1:0]      win, idx;
    logic               found, do_grant, force_exit;
    logic [NUM_REQ-1:0] others;

    // Search starts just after the last owner, so it has lowest priority next time.
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign others     = bus.req & ~(NUM_REQ'(1) << owner_q);
    assign force_exit = (MAX_HOLD != 0) && (hold_q == HW'(HOLD_LAST)) && (|others);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        owner_nxt = owner_q;
        ptr_nxt   = ptr_q;
        oe_nxt    = oe_q;
        dir_nxt   = dir_q;
        busy_nxt  = busy_q;
        hold_nxt  = hold_q;
        turn_nxt  = turn_q;
        do_grant  = 1'b0;
        case (state)
            IDLE: do_grant = found;
            OWN: begin
                if (!bus.req[owner_q] || force_exit) begin
                    state_nxt = TURN;
                    gnt_nxt   = '0;
                    oe_nxt    = 1'b0;
                    dir_nxt   = 1'b0;
                    turn_nxt  = '0;
                end else if (hold_q != HW'(HOLD_LAST)) begin
                    hold_nxt = hold_q + 1'b1;
                end
            end
            TURN: begin
                if (turn_q == TW'(TURN_LAST)) begin
                    if (found) begin
                        do_grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end
                end else begin
                    turn_nxt = turn_q + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (do_grant) begin
            state_nxt    = OWN;
            gnt_nxt      = '0;
            gnt_nxt[win] = 1'b1;
            owner_nxt    = win;
            ptr_nxt      = win;
            dir_nxt      = bus.req_dir[win];
            oe_nxt       = bus.req_dir[win];
            busy_nxt     = 1'b1;
            hold_nxt     = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            oe_q    <= 1'b0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            state   <= state_nxt;
            gnt_q   <= gnt_nxt;
            owner_q <= owner_nxt;
            ptr_q   <= ptr_nxt;
            oe_q    <= oe_nxt;
            dir_q   <= dir_nxt;
            busy_q  <= busy_nxt;
            hold_q  <= hold_nxt;
            turn_q  <= turn_nxt;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.bus_oe  = oe_q;
    assign bus.bus_dir = dir_q;
    assign bus.busy    = busy_q;

`ifdef IOBUS_TURN_ARB_STATS_EN
    logic [7:0] pc_q;
    logic       preempt;

    // A forced exit is one where the owner still wanted the bus.
    assign preempt = (state == OWN) && force_exit && bus.req[owner_q];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= 8'd0;
        end else if (preempt && (pc_q != 8'hFF)) begin
            pc_q <= pc_q + 8'd1;
        end
    end

    assign bus.preempt_cnt = pc_q;
`else
    assign bus.preempt_cnt = 8'd0;
`endif
endmodule
